ram_access_arbiter: RTL and testbench

//  Round-robin arbiter and access sequencer placed in front of the single-port RAM.

---
 rtl/ram_access_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin arbiter and access sequencer for a single-port RAM.
// Two requesters (A, B) share the RAM. Each op runs setup -> strobe -> dout wait -> done.
// Optional RAM parity check is built when RAM_PARITY_CHK_EN is defined.
module ram_access_arbiter #(
    parameter int unsigned MEM_WIDTH = 16,
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned ADDR_LAT  = 2,
    parameter int unsigned DOUT_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [MEM_WIDTH-1:0] a_wdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [MEM_WIDTH-1:0] b_wdata,
    output logic                 a_gnt,
    output logic                 b_gnt,
    output logic                 a_done,
    output logic                 b_done,
    output logic [MEM_WIDTH-1:0] a_rdata,
    output logic [MEM_WIDTH-1:0] b_rdata,
    output logic                 ram_blk_select,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic                 ram_addr_en,
    output logic                 ram_dout_en,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [MEM_WIDTH-1:0] ram_din,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    input  logic                 ram_parity_out,
    output logic                 busy,
    output logic                 par_err
);

    localparam int unsigned MAX_LAT = (ADDR_LAT > DOUT_LAT) ? ADDR_LAT : DOUT_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 owner_b;
    logic                 last_b;
    logic                 op_we;
    logic [ADDR_SIZE-1:0] cap_addr;
    logic [MEM_WIDTH-1:0] cap_wdata;
    logic                 pick_b_c;

    // B wins when it requests alone, or on a tie when A was served last
    assign pick_b_c = b_req && (!a_req || !last_b);

`ifdef RAM_PARITY_CHK_EN
    logic par_mismatch_c;

    // Stored parity bit versus parity recomputed over the returned word
    assign par_mismatch_c = ram_parity_out != (^ram_dout);
`else
    logic unused_parity;

    assign unused_parity = ram_parity_out;
    assign par_err       = 1'b0;
`endif

    // Sequencer; every output is registered from the current state, so the
    // visible phase trails the state register by one cycle (gnt is cycle 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            owner_b        <= 1'b0;
            last_b         <= 1'b1;
            op_we          <= 1'b0;
            cap_addr       <= '0;
            cap_wdata      <= '0;
            a_gnt          <= 1'b0;
            b_gnt          <= 1'b0;
            a_done         <= 1'b0;
            b_done         <= 1'b0;
            a_rdata        <= '0;
            b_rdata        <= '0;
            ram_blk_select <= 1'b0;
            ram_wr_en      <= 1'b0;
            ram_rd_en      <= 1'b0;
            ram_addr_en    <= 1'b0;
            ram_dout_en    <= 1'b0;
            ram_addr       <= '0;
            ram_din        <= '0;
            busy           <= 1'b0;
`ifdef RAM_PARITY_CHK_EN
            par_err        <= 1'b0;
`endif
        end else begin
            a_gnt          <= 1'b0;
            b_gnt          <= 1'b0;
            a_done         <= 1'b0;
            b_done         <= 1'b0;
            ram_blk_select <= 1'b0;
            ram_wr_en      <= 1'b0;
            ram_rd_en      <= 1'b0;
            ram_addr_en    <= 1'b0;
            ram_dout_en    <= 1'b0;
            busy           <= (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    if (a_req || b_req) begin
                        a_gnt     <= !pick_b_c;
                        b_gnt     <= pick_b_c;
                        owner_b   <= pick_b_c;
                        last_b    <= pick_b_c;
                        op_we     <= pick_b_c ? b_we    : a_we;
                        cap_addr  <= pick_b_c ? b_addr  : a_addr;
                        cap_wdata <= pick_b_c ? b_wdata : a_wdata;
                        cnt       <= '0;
                        state     <= (ADDR_LAT == 0) ? S_ACCESS : S_SETUP;
                    end
                end

                S_SETUP: begin
                    ram_blk_select <= 1'b1;
                    ram_addr_en    <= 1'b1;
                    ram_addr       <= cap_addr;
                    ram_din        <= cap_wdata;
                    if (cnt == CNT_W'(ADDR_LAT - 1)) begin
                        cnt   <= '0;
                        state <= S_ACCESS;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_ACCESS: begin
                    ram_blk_select <= 1'b1;
                    ram_addr_en    <= 1'b1;
                    ram_addr       <= cap_addr;
                    ram_din        <= cap_wdata;
                    ram_wr_en      <= op_we;
                    ram_rd_en      <= !op_we;
                    cnt            <= '0;
                    state          <= (!op_we && (DOUT_LAT != 0)) ? S_WAIT : S_DONE;
                end

                S_WAIT: begin
                    ram_dout_en <= 1'b1;
                    if (cnt == CNT_W'(DOUT_LAT - 1)) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    // ram_dout is sampled here, at the end of the last dout-wait cycle
                    a_done <= !owner_b;
                    b_done <= owner_b;
                    if (!op_we) begin
                        if (owner_b) b_rdata <= ram_dout;
                        else         a_rdata <= ram_dout;
`ifdef RAM_PARITY_CHK_EN
                        if (par_mismatch_c) par_err <= 1'b1;
`endif
                    end
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed and randomized checks of ram_access_arbiter
// against a transaction-level reference (RR winner, latency, memory contents).
module tb_ram_access_arbiter;

    localparam int unsigned MW = 16;
    localparam int unsigned AW = 10;
    localparam int unsigned AL = 2;
    localparam int unsigned DL = 2;

`ifdef RAM_PARITY_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main DUT (default latencies)
    logic          a_req = 0, b_req = 0, a_we = 0, b_we = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [MW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, b_gnt, a_done, b_done;
    logic [MW-1:0] a_rdata, b_rdata;
    logic          ram_blk_select, ram_wr_en, ram_rd_en, ram_addr_en, ram_dout_en;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_din, ram_dout;
    logic          ram_parity_out, busy, par_err;

    ram_access_arbiter #(.MEM_WIDTH(MW), .ADDR_SIZE(AW), .ADDR_LAT(AL), .DOUT_LAT(DL)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .ram_blk_select(ram_blk_select), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .ram_addr_en(ram_addr_en), .ram_dout_en(ram_dout_en),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_parity_out(ram_parity_out), .busy(busy), .par_err(par_err)
    );

    // Zero-latency DUT
    logic          z_a_req = 0, z_a_we = 0;
    logic [AW-1:0] z_a_addr = '0;
    logic [MW-1:0] z_a_wdata = '0;
    logic          z_a_gnt, z_b_gnt, z_a_done, z_b_done;
    logic [MW-1:0] z_a_rdata, z_b_rdata;
    logic          z_blk, z_ram_wr_en, z_ram_rd_en, z_addr_en, z_dout_en;
    logic [AW-1:0] z_ram_addr;
    logic [MW-1:0] z_ram_din, z_ram_dout;
    logic          z_parity, z_busy, z_par_err;

    ram_access_arbiter #(.MEM_WIDTH(MW), .ADDR_SIZE(AW), .ADDR_LAT(0), .DOUT_LAT(0)) dut_z (
        .clk(clk), .rst(rst),
        .a_req(z_a_req), .a_we(z_a_we), .a_addr(z_a_addr), .a_wdata(z_a_wdata),
        .b_req(1'b0), .b_we(1'b0), .b_addr('0), .b_wdata('0),
        .a_gnt(z_a_gnt), .b_gnt(z_b_gnt), .a_done(z_a_done), .b_done(z_b_done),
        .a_rdata(z_a_rdata), .b_rdata(z_b_rdata),
        .ram_blk_select(z_blk), .ram_wr_en(z_ram_wr_en), .ram_rd_en(z_ram_rd_en),
        .ram_addr_en(z_addr_en), .ram_dout_en(z_dout_en),
        .ram_addr(z_ram_addr), .ram_din(z_ram_din), .ram_dout(z_ram_dout),
        .ram_parity_out(z_parity), .busy(z_busy), .par_err(z_par_err)
    );

    // RAM environment models: DL-cycle read pipe for the main DUT, combinational for the zero-latency one
    logic [MW-1:0] ram_mem [0:(1<<AW)-1];
    logic [MW-1:0] z_mem   [0:(1<<AW)-1];
    logic [MW-1:0] rd_pipe1 = '0, rd_pipe2 = '0;
    logic          par_flip = 1'b0;

    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_addr] <= ram_din;
        if (ram_rd_en) rd_pipe1 <= ram_mem[ram_addr];
        rd_pipe2 <= rd_pipe1;
        if (z_ram_wr_en) z_mem[z_ram_addr] <= z_ram_din;
    end
    assign ram_dout       = rd_pipe2;
    assign ram_parity_out = (^ram_dout) ^ par_flip;
    assign z_ram_dout     = z_mem[z_ram_addr];
    assign z_parity       = ^z_ram_dout;

    // Reference model state
    logic [MW-1:0] ref_mem [0:(1<<AW)-1];
    bit            ref_last_b = 1'b1;
    bit            exp_par    = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {a_gnt, b_gnt, a_done, b_done, ram_blk_select, ram_wr_en,
                              ram_rd_en, ram_addr_en, ram_dout_en, busy, par_err}, 0);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_din"}, ram_din, 0);
        check({tag, "_rdata"}, {a_rdata, b_rdata}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; a_req = 0; b_req = 0; z_a_req = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        ref_last_b = 1'b1;
        exp_par    = 1'b0;
    endtask

    task automatic wait_gnt(output bit got_b, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(a_gnt || b_gnt) && n < 20);
        check("gnt_exclusive", a_gnt & b_gnt, 0);
        got_b = b_gnt;
    endtask

    // Follows one granted op from cycle 0 to its done pulse
    task automatic track(input bit own_b, input bit we, input logic [AW-1:0] addr,
                         input logic [MW-1:0] wd);
        int k = 0;
        int nstr = 0;
        int str_k = -1;
        bit seen = 0;
        int exp_lat;
        exp_lat = we ? int'(AL + 2) : int'(AL + DL + 2);
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (ram_wr_en || ram_rd_en) begin
                nstr++;
                str_k = k;
                check("strobe_kind", {ram_rd_en, ram_wr_en}, {!we, we});
                check("strobe_addr", ram_addr, addr);
                if (we) check("strobe_din", ram_din, wd);
                check("strobe_busy", busy, 1);
            end
            if (a_done || b_done) seen = 1;
        end
        check("done_seen", seen, 1);
        check("done_owner", {b_done, a_done}, own_b ? 2 : 1);
        check("done_no_gnt", {b_gnt, a_gnt}, 0);
        check("done_latency", k, exp_lat);
        check("strobe_count", nstr, 1);
        check("strobe_cycle", str_k, AL + 1);
        if (!we) check(own_b ? "b_rdata" : "a_rdata", own_b ? b_rdata : a_rdata, ref_mem[addr]);
        else     ref_mem[addr] = wd;
        check("par_err", par_err, exp_par);
    endtask

    // Raise the given requests and follow every resulting grant to completion
    task automatic serve(input bit ra, input bit rb);
        bit pa, pb, wb, exp_b;
        int n;
        pa = ra; pb = rb;
        a_req = ra; b_req = rb;
        while (pa || pb) begin
            exp_b = pb && (!pa || !ref_last_b);
            wait_gnt(wb, n);
            check("gnt_delay", n, 1);
            check("gnt_winner", {b_gnt, a_gnt}, exp_b ? 2 : 1);
            ref_last_b = exp_b;
            if (exp_b) begin
                b_req = 0; pb = 0;
                track(1'b1, b_we, b_addr, b_wdata);
            end else begin
                a_req = 0; pa = 0;
                track(1'b0, a_we, a_addr, a_wdata);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wb, exp_b, any;
        int n, k;
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            z_mem[i]   = '0;
            ref_mem[i] = '0;
        end

        do_reset();

        // Write then read back through requester A
        a_we = 1; a_addr = 10'h005; a_wdata = 16'hBEEF;
        serve(1'b1, 1'b0);
        a_we = 0;
        serve(1'b1, 1'b0);
        check("readback_beef", a_rdata, 16'hBEEF);

        // Both held from reset: strict A,B,A,B alternation
        do_reset();
        a_we = 1; a_addr = 10'h010; a_wdata = MW'($urandom);
        b_we = 0; b_addr = 10'h005;
        a_req = 1; b_req = 1;
        for (int i = 0; i < 4; i++) begin
            exp_b = (i % 2) == 1;
            wait_gnt(wb, n);
            check("rr_delay", n, 1);
            check("rr_order", {b_gnt, a_gnt}, exp_b ? 2 : 1);
            ref_last_b = exp_b;
            if (i == 3) begin a_req = 0; b_req = 0; end
            if (exp_b) track(1'b1, b_we, b_addr, b_wdata);
            else       track(1'b0, a_we, a_addr, a_wdata);
        end

        // Reset during the dout wait of a B read
        b_we = 0; b_addr = 10'h005; b_req = 1;
        wait_gnt(wb, n);
        check("rst_op_gnt", {b_gnt, a_gnt}, 2);
        b_req = 0;
        k = 0;
        do begin @(negedge clk); k++; end while (!ram_dout_en && k < 20);
        check("rst_wait_reached", ram_dout_en, 1);
        rst = 1;
        @(negedge clk);
        check_all_zero("midop_reset");
        rst = 0;
        ref_last_b = 1'b1;
        any = 0;
        repeat (8) begin
            @(negedge clk);
            any |= a_done | b_done | busy;
        end
        check("no_done_after_rst", any, 0);
        a_we = 0; a_addr = 10'h005;
        serve(1'b1, 1'b1);

        // Zero-latency build: write strobe c1, done c2; read done c2
        z_a_we = 1; z_a_addr = 10'h003; z_a_wdata = 16'h1234; z_a_req = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!z_a_gnt && n < 20);
        check("z_wgnt", z_a_gnt, 1);
        z_a_req = 0;
        @(negedge clk);
        check("z_wstrobe", {z_ram_rd_en, z_ram_wr_en}, 1);
        check("z_waddr", z_ram_addr, 10'h003);
        check("z_wdin", z_ram_din, 16'h1234);
        @(negedge clk);
        check("z_wdone", z_a_done, 1);
        z_a_we = 0; z_a_req = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!z_a_gnt && n < 20);
        check("z_rgnt", z_a_gnt, 1);
        z_a_req = 0;
        @(negedge clk);
        check("z_rstrobe", {z_ram_rd_en, z_ram_wr_en}, 2);
        @(negedge clk);
        check("z_rdone", z_a_done, 1);
        check("z_rdata", z_a_rdata, 16'h1234);

        // Randomized mix of single and contended requests
        for (int it = 0; it < 40; it++) begin
            int mode;
            mode = int'($urandom_range(1, 3));
            a_we = 1'($urandom); a_addr = AW'($urandom_range(0, 15)); a_wdata = MW'($urandom);
            b_we = 1'($urandom); b_addr = AW'($urandom_range(0, 15)); b_wdata = MW'($urandom);
            serve(mode[0], mode[1]);
        end

        // Parity: corrupt one read, flag must stick until reset
        b_we = 0; b_addr = 10'h005;
        ref_mem[10'h005] = ref_mem[10'h005];
        par_flip = 1;
        exp_par  = PAR_EN;
        serve(1'b0, 1'b1);
        par_flip = 0;
        a_we = 0; a_addr = 10'h005;
        serve(1'b1, 1'b0);
        check("par_sticky", par_err, PAR_EN);
        do_reset();
        check("par_cleared", par_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
